// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, oversampled on BusClk with mid-bit sampling.
// Presents one received byte in a holding register with Full/FrameErr/Overrun flags.
module uart_rx #(
    parameter int PRESCALER = 625
) (
    input  logic        BusClk,
    input  logic        BusRst,
    input  logic        BusRd,
    input  logic        PhyIn,
    output logic [31:0] BusData,
    output logic        Full,
    output logic        FrameErr,
    output logic        Overrun
);

    localparam int HALF = PRESCALER / 2;
    localparam logic [11:0] PCNT_BIT  = 12'(PRESCALER - 1);
    localparam logic [11:0] PCNT_HALF = 12'(HALF - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;

    logic        sync0;
    logic        rx;
    logic [2:0]  state;
    logic [11:0] pcnt;
    logic [2:0]  bitcnt;
    logic [7:0]  shift;
    logic [7:0]  data;
    logic        stop_sample;
    logic        stop_ok;
    logic        stop_bad;

    // NOTE: both flops reset to the idle-high level so a reset never looks like a start edge.
    always_ff @(posedge BusClk) begin
        if (BusRst) begin
            sync0 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync0 <= PhyIn;
            rx    <= sync0;
        end
    end

    assign stop_sample = (state == STOP) && (pcnt == PCNT_BIT);
    assign stop_ok     = stop_sample && rx;
    assign stop_bad    = stop_sample && !rx;

    always_ff @(posedge BusClk) begin
        if (BusRst) begin
            state  <= IDLE;
            pcnt   <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        pcnt  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (pcnt == PCNT_HALF) begin
                        if (!rx) begin
                            pcnt   <= '0;
                            bitcnt <= '0;
                            state  <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        pcnt <= pcnt + 12'd1;
                    end
                end
                DATA: begin
                    if (pcnt == PCNT_BIT) begin
                        shift  <= {rx, shift[7:1]};
                        pcnt   <= '0;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= STOP;
                    end else begin
                        pcnt <= pcnt + 12'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                    if (pcnt == PCNT_BIT) begin
                        pcnt  <= '0;
                        state <= rx ? IDLE : WAIT_HI;
                    end else begin
                        pcnt <= pcnt + 12'd1;
                    end
                end
                WAIT_HI: begin
                    if (rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read in the same cycle as a valid stop frees the register, so the new byte lands.
    always_ff @(posedge BusClk) begin
        if (BusRst) begin
            data     <= '0;
            Full     <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            if (stop_ok && (!Full || BusRd)) begin
                data <= shift;
                Full <= 1'b1;
            end else if (BusRd) begin
                Full <= 1'b0;
            end

            if (stop_ok && Full && !BusRd) Overrun <= 1'b1;
            else if (BusRd)                Overrun <= 1'b0;

            if (stop_bad)   FrameErr <= 1'b1;
            else if (BusRd) FrameErr <= 1'b0;
        end
    end

    assign BusData = {24'd0, data};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 cycles/bit; inputs driven and outputs sampled on negedge.
module tb_uart_rx;

    localparam int P = 16;

    logic        BusClk = 1'b0;
    logic        BusRst;
    logic        BusRd;
    logic        PhyIn;
    logic [31:0] BusData;
    logic        Full;
    logic        FrameErr;
    logic        Overrun;

    int checks = 0;
    int errors = 0;

    always #5 BusClk = ~BusClk;

    uart_rx #(.PRESCALER(P)) dut (
        .BusClk  (BusClk),
        .BusRst  (BusRst),
        .BusRd   (BusRd),
        .PhyIn   (PhyIn),
        .BusData (BusData),
        .Full    (Full),
        .FrameErr(FrameErr),
        .Overrun (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        PhyIn = 1'b1;
        BusRd = 1'b0;
        repeat (n) @(negedge BusClk);
    endtask

    task automatic do_read();
        BusRd = 1'b1;
        @(negedge BusClk);
        BusRd = 1'b0;
    endtask

    // Drives one 10-bit frame. rd_at: 1-based posedge (after the falling edge) whose
    // preceding cycle has BusRd high, 0 for none. rise_at: posedge where Full first rose.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at,
                              output int rise_at);
        logic [9:0] bits;
        logic       prev;
        bits    = {stop, d, 1'b0};
        rise_at = 0;
        prev    = Full;
        for (int i = 0; i < 10 * P; i++) begin
            PhyIn = bits[i / P];
            BusRd = (i + 1 == rd_at);
            @(negedge BusClk);
            if (Full && !prev && rise_at == 0) rise_at = i + 1;
            prev = Full;
        end
        BusRd = 1'b0;
    endtask

    initial begin
        int         r;
        logic [9:0] part;

        // 1. Reset with a toggling line, then reset in the middle of DATA bit 3
        BusRst = 1'b1;
        BusRd  = 1'b0;
        PhyIn  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PhyIn = i[0];
            @(negedge BusClk);
        end
        BusRst = 1'b0;
        PhyIn  = 1'b1;
        check("rst_data", BusData, 32'h0);
        check("rst_full", {31'd0, Full}, 32'd0);
        check("rst_ferr", {31'd0, FrameErr}, 32'd0);
        check("rst_ovr", {31'd0, Overrun}, 32'd0);
        idle(5);

        part = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 4 * P + 8; i++) begin
            PhyIn = part[i / P];
            @(negedge BusClk);
        end
        BusRst = 1'b1;
        PhyIn  = 1'b1;
        repeat (2) @(negedge BusClk);
        BusRst = 1'b0;
        idle(3 * P);
        check("midrst_full", {31'd0, Full}, 32'd0);
        check("midrst_ferr", {31'd0, FrameErr}, 32'd0);
        check("midrst_ovr", {31'd0, Overrun}, 32'd0);
        send_frame(8'h5A, 1'b1, 0, r);
        check("after_rst_data", BusData, 32'h0000_005A);
        check("after_rst_full", {31'd0, Full}, 32'd1);
        do_read();
        check("after_rst_read_full", {31'd0, Full}, 32'd0);

        // 2. Single frame latency and read
        idle(10);
        send_frame(8'hA5, 1'b1, 0, r);
        check("a5_latency", r, 32'd155);
        check("a5_data", BusData, 32'h0000_00A5);
        check("a5_ferr", {31'd0, FrameErr}, 32'd0);
        check("a5_ovr", {31'd0, Overrun}, 32'd0);
        do_read();
        check("a5_read_full", {31'd0, Full}, 32'd0);
        check("a5_read_data", BusData, 32'h0000_00A5);

        // 3. Short low glitch is rejected
        idle(10);
        PhyIn = 1'b0;
        repeat (5) @(negedge BusClk);
        idle(2 * P);
        check("glitch_full", {31'd0, Full}, 32'd0);
        check("glitch_ferr", {31'd0, FrameErr}, 32'd0);
        check("glitch_ovr", {31'd0, Overrun}, 32'd0);
        send_frame(8'h3C, 1'b1, 0, r);
        check("glitch_next_data", BusData, 32'h0000_003C);
        check("glitch_next_full", {31'd0, Full}, 32'd1);
        do_read();

        // 4. Framing error, stuck-low line, recovery
        idle(10);
        send_frame(8'h3C, 1'b0, 0, r);
        check("fe_ferr", {31'd0, FrameErr}, 32'd1);
        check("fe_full", {31'd0, Full}, 32'd0);
        PhyIn = 1'b0;
        repeat (40) @(negedge BusClk);
        check("fe_low_full", {31'd0, Full}, 32'd0);
        idle(2 * P);
        send_frame(8'h11, 1'b1, 0, r);
        check("fe_next_data", BusData, 32'h0000_0011);
        check("fe_next_full", {31'd0, Full}, 32'd1);
        check("fe_sticky", {31'd0, FrameErr}, 32'd1);
        check("fe_next_ovr", {31'd0, Overrun}, 32'd0);
        do_read();
        check("fe_read_ferr", {31'd0, FrameErr}, 32'd0);
        check("fe_read_full", {31'd0, Full}, 32'd0);

        // 5. Overrun on back-to-back frames without a read
        idle(10);
        send_frame(8'h01, 1'b1, 0, r);
        send_frame(8'h02, 1'b1, 0, r);
        check("ovr_data", BusData, 32'h0000_0001);
        check("ovr_full", {31'd0, Full}, 32'd1);
        check("ovr_flag", {31'd0, Overrun}, 32'd1);
        check("ovr_ferr", {31'd0, FrameErr}, 32'd0);
        do_read();
        check("ovr_read_full", {31'd0, Full}, 32'd0);
        check("ovr_read_ovr", {31'd0, Overrun}, 32'd0);
        check("ovr_read_ferr", {31'd0, FrameErr}, 32'd0);

        // 6. Read collides with the second frame's stop sample
        idle(10);
        send_frame(8'h0F, 1'b1, 0, r);
        check("coll_first_data", BusData, 32'h0000_000F);
        send_frame(8'hF0, 1'b1, 155, r);
        check("coll_data", BusData, 32'h0000_00F0);
        check("coll_full", {31'd0, Full}, 32'd1);
        check("coll_ovr", {31'd0, Overrun}, 32'd0);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Synchronous UART receiver on the bus clock. It is the counterpart to the UART TX stage and consumes the serial stream that stage produces (8 data bits, no parity, 1 stop bit, LSB first).
It oversamples PhyIn, validates the start bit at mid-bit, and shifts in 8 data bits sampled at mid-bit. It checks the stop bit and presents the byte in a single holding register with Full, FrameErr and Overrun flags. The register is mapped next to the TX data register.

Parameters:
PRESCALER, 625, bus clock cycles per bit (9600 baud at 6 MHz); legal range 4..4095
HALF, PRESCALER/2 (integer divide), cycles from the synchronised falling edge to the start-bit mid sample; derived, not overridden

Ports:
BusClk  in  1  bus clock; all logic on posedge
BusRst  in  1  synchronous reset, active-high
BusRd  in  1  read strobe, one cycle; acknowledges the holding register
PhyIn  in  1  asynchronous serial line, idle high
BusData  out  32  received byte in [7:0], bits [31:8] always 0
Full  out  1  holding register contains an unread byte
FrameErr  out  1  sticky: a frame ended with stop bit = 0
Overrun  out  1  sticky: a valid byte was dropped because Full was set

Behaviour:
- Reset (BusRst=1 at a posedge):
  - BusData=0, Full=0, FrameErr=0, Overrun=0.
  - Both sync flops=1, state=IDLE, counters and shift register=0.
  - Reset mid-frame aborts the frame with no flag set.
- Input sync:
  - Two-flop synchroniser on PhyIn gives Rx.
  - Latency is 2 cycles; all decisions use Rx only.
- Counters:
  - PCnt is 12 bits and counts 0..PRESCALER-1 (or 0..HALF-1 in START).
  - BitCnt is 3 bits.
- States: IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE: when Rx=0, set PCnt=0 and go to START.
  - START: increment PCnt. When PCnt==HALF-1, sample Rx:
    - Rx=0: set PCnt=0, BitCnt=0, go to DATA.
    - Rx=1: glitch; go to IDLE with no flags.
  - DATA: increment PCnt. When PCnt==PRESCALER-1, sample:
    - Shift <= {Rx, Shift[7:1]} (LSB first), PCnt=0, BitCnt+1.
    - After the 8th sample (BitCnt==7 wrapping to 0) go to STOP.
  - STOP: when PCnt==PRESCALER-1, sample:
    - Rx=1 (valid frame): if Full=0 or BusRd=1 this cycle, then BusData[7:0]<=Shift and Full<=1. Otherwise Overrun<=1 and BusData is unchanged (the new byte is dropped). Go to IDLE.
    - Rx=0 (framing error): FrameErr<=1, byte discarded, Full/BusData unchanged, go to WAIT_HI.
  - WAIT_HI: stay until Rx=1, then go to IDLE. This prevents a break or stuck-low line from being read as repeated start bits.
- Timing:
  - Let t = first cycle with Rx=0 in IDLE.
  - Start sample at t+1+HALF-1.
  - Data bit n sample at start sample + (n+1)*PRESCALER.
  - Stop sample at start sample + 9*PRESCALER.
  - Full, BusData and flags are visible the cycle after the stop sample.
- Back-to-back frames: leaving STOP at mid-stop-bit guarantees the next start edge is seen even with 0 idle time.
- BusRd behaviour:
  - On BusRd=1, the next cycle clears Full, FrameErr and Overrun.
  - Same cycle as a valid stop sample: the new byte loads, Full stays 1, Overrun is not set, FrameErr clears.
  - Same cycle as a framing error: FrameErr ends at 1 (set wins over clear), Full clears.
- BusRd has no effect on the receive state machine.
- BusData holds its value after a read until the next valid frame.

Test Plan:
All tests use PRESCALER=16 (HALF=8), with PhyIn driven at 16 cycles/bit.
1. Reset: assert BusRst 3 cycles with PhyIn toggling -> BusData=0, Full=FrameErr=Overrun=0. Assert BusRst during DATA bit 3 -> no flags set; the next full frame 0x5A is received correctly.
2. Single frame 0xA5 -> Full=1 exactly 2+8+9*16+1 cycles after the PhyIn falling edge, BusData=0x000000A5, no error flags. BusRd -> Full=0 next cycle, BusData still 0xA5.
3. Glitch: PhyIn low for 5 cycles, then high -> state back to IDLE, Full=0, no flags. A subsequent 0x3C frame is received correctly.
4. Framing error: 0x3C with stop bit 0, then line held low 40 cycles, then high, then frame 0x11 -> FrameErr=1 and Full=0 after the first frame, no spurious start during the low period, then Full=1 with BusData=0x11 and FrameErr still 1 until BusRd.
5. Overrun: frames 0x01 then 0x02 back-to-back with 0 idle, no read -> BusData=0x01, Full=1, Overrun=1. BusRd -> all three flags 0.
6. Read collision: frames 0x0F then 0xF0, with BusRd pulsed exactly in the second frame's stop-sample cycle -> BusData=0xF0, Full=1, Overrun=0.
